// File: rtl/aes_mixcol_state_engine.sv
// Iterative AES MixColumns/InvMixColumns over a 128-bit state, one column per clock.
// Column c of the state sits at bits [127-32c -: 32]; byte A is the top byte of a column.

module aes_mixcol_column (
  input  logic [31:0] col,
  input  logic        inverse,
  output logic [31:0] res
);
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m2(input logic [7:0] v);
    return xt(v);
  endfunction

  function automatic logic [7:0] m3(input logic [7:0] v);
    return xt(v) ^ v;
  endfunction

  // Inverse multipliers share the x2/x4/x8 chain
  function automatic logic [7:0] m9(input logic [7:0] v);
    return xt(xt(xt(v))) ^ v;
  endfunction

  function automatic logic [7:0] mb(input logic [7:0] v);
    return xt(xt(xt(v))) ^ xt(v) ^ v;
  endfunction

  function automatic logic [7:0] md(input logic [7:0] v);
    return xt(xt(xt(v))) ^ xt(xt(v)) ^ v;
  endfunction

  function automatic logic [7:0] me(input logic [7:0] v);
    return xt(xt(xt(v))) ^ xt(xt(v)) ^ xt(v);
  endfunction

  logic [7:0] a, b, c, d;
  assign {a, b, c, d} = col;

  always_comb begin
    res = '0;
    if (inverse)
      res = {me(a) ^ mb(b) ^ md(c) ^ m9(d),
             m9(a) ^ me(b) ^ mb(c) ^ md(d),
             md(a) ^ m9(b) ^ me(c) ^ mb(d),
             mb(a) ^ md(b) ^ m9(c) ^ me(d)};
    else
      res = {m2(a) ^ m3(b) ^ c ^ d,
             a ^ m2(b) ^ m3(c) ^ d,
             a ^ b ^ m2(c) ^ m3(d),
             m3(a) ^ b ^ c ^ m2(d)};
  end
endmodule

module aes_mixcol_state_engine (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      col_cnt;
  logic            mode;
  logic            in_ready_q, out_valid_q;
  logic [3:0][31:0] work, result;
  logic [31:0]     col_res;

  // Column 0 is the most significant word, so packed index is ~col_cnt
  aes_mixcol_column u_col (
    .col     (work[~col_cnt]),
    .inverse (mode),
    .res     (col_res)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && in_ready_q) state_d = RUN;
      RUN:     if (col_cnt == 2'd3) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work        <= '0;
      result      <= '0;
      col_cnt     <= '0;
      mode        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            work       <= in_state;
            mode       <= in_inverse;
            col_cnt    <= 2'd0;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          result[~col_cnt] <= col_res;
          col_cnt          <= col_cnt + 2'd1;
          if (col_cnt == 2'd3) out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = result;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_aes_mixcol_state_engine.sv
// Scoreboard bench for aes_mixcol_state_engine: directed vectors plus a GF(2^8) model.
module tb_aes_mixcol_state_engine;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         in_inverse = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_state;
  logic         busy;

  aes_mixcol_state_engine dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_inverse(in_inverse), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [127:0] exp_q[$];
  bit stream_chk = 1'b0;
  int stream_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference multiply: plain shift-and-add with 0x11B reduction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [127:0] r = '0;
    logic [7:0] k0, k1, k2, k3;
    logic [7:0] c [4];
    {k0, k1, k2, k3} = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int col = 0; col < 4; col++) begin
      for (int j = 0; j < 4; j++) c[j] = s[127 - 32*col - 8*j -: 8];
      // Row i uses the coefficient row rotated right by i
      r[127-32*col -: 8]    = gmul(c[0],k0) ^ gmul(c[1],k1) ^ gmul(c[2],k2) ^ gmul(c[3],k3);
      r[127-32*col-8 -: 8]  = gmul(c[0],k3) ^ gmul(c[1],k0) ^ gmul(c[2],k1) ^ gmul(c[3],k2);
      r[127-32*col-16 -: 8] = gmul(c[0],k2) ^ gmul(c[1],k3) ^ gmul(c[2],k0) ^ gmul(c[3],k1);
      r[127-32*col-24 -: 8] = gmul(c[0],k1) ^ gmul(c[1],k2) ^ gmul(c[2],k3) ^ gmul(c[3],k0);
    end
    return r;
  endfunction

  // Monitor: handshake pops scoreboard, also latency and stream cadence
  int acc_cyc = 0;
  int last_acc = 0;
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) begin
        if (stream_chk && stream_n > 0) check("stream_period", 128'(cyc - last_acc), 128'd6);
        if (stream_chk) stream_n++;
        last_acc = cyc;
        acc_cyc = cyc;
      end
      if (out_valid && !prev_ov) check("latency", 128'(cyc - acc_cyc), 128'd5);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got %h expected none", out_state);
        end else begin
          check("result", out_state, exp_q.pop_front());
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [127:0] s, input logic inv, input logic [127:0] exp);
    in_valid = 1'b1; in_state = s; in_inverse = inv;
    exp_q.push_back(exp);
    wait_accept();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_MIXED = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V_FIPS  = 128'hd4bf5d30_00000000_00000000_00000000;
  localparam logic [127:0] V_FIPSM = 128'h046681e5_00000000_00000000_00000000;
  localparam logic [127:0] V_R1    = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V_R1M   = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] V_ONES  = {16{8'h01}};

  initial begin
    #12;
    check("reset_in_ready", 128'(in_ready), 128'd0);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_out_state", out_state, 128'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_reset", 128'(in_ready), 128'd1);

    // Directed forward/inverse and FIPS-197 column
    send(V_PLAIN, 1'b0, V_MIXED);
    drain();
    send(V_MIXED, 1'b1, V_PLAIN);
    drain();
    send(V_FIPS, 1'b0, V_FIPSM);
    drain();
    send(V_FIPSM, 1'b1, V_FIPS);
    drain();

    // Backpressure with scrambled inputs after accept
    begin
      bit seen = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1; in_state = V_R1; in_inverse = 1'b0;
      exp_q.push_back(V_R1M);
      wait_accept();
      for (int i = 0; i < 20 && !seen; i++) begin
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_inverse = 1'($urandom);
        check("bp_in_ready_run", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        if (out_valid) seen = 1'b1;
      end
      check("bp_out_valid_seen", 128'(seen), 128'd1);
      for (int i = 0; i < 10; i++) begin
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_inverse = 1'($urandom);
        @(posedge clk); #1;
        check("bp_out_state", out_state, V_R1M);
        check("bp_out_valid", 128'(out_valid), 128'd1);
        check("bp_in_ready", 128'(in_ready), 128'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_in_ready_after", 128'(in_ready), 128'd1);
      check("bp_out_valid_after", 128'(out_valid), 128'd0);
      check("bp_out_state_kept", out_state, V_R1M);
      drain();
    end

    // Back-to-back streaming against the model
    stream_n = 0;
    stream_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [127:0] s;
      logic m;
      s = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom);
      send(s, m, model(s, m));
    end
    drain();
    stream_chk = 1'b0;
    check("stream_count", 128'(stream_n), 128'd8);

    // Reset two cycles into RUN
    in_valid = 1'b1; in_state = V_R1; in_inverse = 1'b0;
    wait_accept();
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_run_out_valid", 128'(out_valid), 128'd0);
    check("rst_run_busy", 128'(busy), 128'd0);
    check("rst_run_out_state", out_state, 128'h0);
    check("rst_run_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1 reset = 1'b0;
    send(V_ONES, 1'b0, V_ONES);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
